// File: rtl/piezo_pkg.sv
// Shared alarm note definitions: note LIMIT half-periods, note codes and decoder FSM states.
package piezo_pkg;

    localparam int unsigned LIMIT_DO  = 190;
    localparam int unsigned LIMIT_RAE = 169;
    localparam int unsigned LIMIT_MI  = 151;
    localparam int unsigned LIMIT_FA  = 142;
    localparam int unsigned LIMIT_SOL = 127;
    localparam int unsigned LIMIT_RA  = 113;
    localparam int unsigned LIMIT_SI  = 100;
    localparam int unsigned LIMIT_HDO = 95;

    localparam int NUM_NOTES = 8;

    localparam logic [3:0] NOTE_REST    = 4'd0;
    localparam logic [3:0] NOTE_DO      = 4'd1;
    localparam logic [3:0] NOTE_RAE     = 4'd2;
    localparam logic [3:0] NOTE_MI      = 4'd3;
    localparam logic [3:0] NOTE_FA      = 4'd4;
    localparam logic [3:0] NOTE_SOL     = 4'd5;
    localparam logic [3:0] NOTE_RA      = 4'd6;
    localparam logic [3:0] NOTE_SI      = 4'd7;
    localparam logic [3:0] NOTE_HDO     = 4'd8;
    localparam logic [3:0] NOTE_UNKNOWN = 4'd15;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_ARM    = 2'd1,
        ST_TRACK  = 2'd2
    } state_e;

    function automatic int unsigned note_limit(input logic [3:0] code);
        case (code)
            NOTE_DO:  return LIMIT_DO;
            NOTE_RAE: return LIMIT_RAE;
            NOTE_MI:  return LIMIT_MI;
            NOTE_FA:  return LIMIT_FA;
            NOTE_SOL: return LIMIT_SOL;
            NOTE_RA:  return LIMIT_RA;
            NOTE_SI:  return LIMIT_SI;
            NOTE_HDO: return LIMIT_HDO;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/piezo_note_classifier.sv
// Combinational map from a measured half-period count to a note code.
module piezo_note_classifier
    import piezo_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int TOL   = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    output logic [3:0]       note_o
);

    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] diff;
    logic             found;

    always_comb begin
        note_o = NOTE_UNKNOWN;
        found  = 1'b0;
        lim    = '0;
        diff   = '0;
        // Earlier table entries take priority when tolerance windows overlap.
        for (int k = 1; k <= NUM_NOTES; k++) begin
            lim  = CNT_W'(note_limit(4'(k)));
            diff = (cnt_i >= lim) ? (cnt_i - lim) : (lim - cnt_i);
            if (!found && (diff <= CNT_W'(TOL))) begin
                note_o = 4'(k);
                found  = 1'b1;
            end
        end
        if (cnt_i <= CNT_W'(1)) begin
            note_o = NOTE_REST;
        end
    end

endmodule

// File: rtl/piezo_tone_decoder.sv
// Measures the half-period of a square-wave tone, classifies it against the alarm
// note table and reports a debounced note code.
module piezo_tone_decoder
    import piezo_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TOL         = 2,
    parameter int CONFIRM     = 3,
    parameter int SILENCE_CYC = 2000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             TONE_IN,
    output logic [3:0]       NOTE,
    output logic             NOTE_VALID,
    output logic [CNT_W-1:0] PERIOD,
    output logic             LOCKED
);

    logic             sync1_q, sync2_q, prev_q;
    logic             tone_edge;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cls;
    logic             timeout;

    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [2:0]       match_q, match_d;
    logic [3:0]       note_q, note_d;
    logic             nv_q, nv_d;
    logic [CNT_W-1:0] period_q, period_d;

    // Synchronizer and edge register carry no control meaning, so they run through reset.
    always_ff @(posedge CLK) begin
        sync1_q <= TONE_IN;
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
    end

    assign tone_edge = sync2_q ^ prev_q;

    always_comb begin
        if (tone_edge) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    piezo_note_classifier #(
        .CNT_W (CNT_W),
        .TOL   (TOL)
    ) u_classifier (
        .cnt_i  (cnt_q),
        .note_o (cls)
    );

    assign timeout = (state_q != ST_SILENT) && !tone_edge
                     && (cnt_q == CNT_W'(SILENCE_CYC - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q    <= '0;
            state_q  <= ST_SILENT;
            cand_q   <= NOTE_REST;
            match_q  <= '0;
            note_q   <= NOTE_REST;
            nv_q     <= 1'b0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            note_q   <= note_d;
            nv_q     <= nv_d;
            period_q <= period_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        note_d   = note_q;
        nv_d     = 1'b0;
        period_d = period_q;
        if (!ENABLE || timeout) begin
            state_d = ST_SILENT;
            match_d = '0;
            note_d  = NOTE_REST;
            nv_d    = (note_q != NOTE_REST);
        end else if (tone_edge) begin
            case (state_q)
                ST_SILENT: state_d = ST_ARM;
                ST_ARM: begin
                    period_d = cnt_q;
                    cand_d   = cls;
                    match_d  = 3'd1;
                    state_d  = ST_TRACK;
                end
                ST_TRACK: begin
                    period_d = cnt_q;
                    if (cls == cand_q) begin
                        match_d = (match_q == 3'd7) ? 3'd7 : match_q + 3'd1;
                    end else begin
                        cand_d  = cls;
                        match_d = 3'd1;
                    end
                end
                default: state_d = ST_SILENT;
            endcase
            // Arming edge also counts, so CONFIRM=1 updates on the first measurement.
            if ((state_q != ST_SILENT) && (match_d >= 3'(CONFIRM)) && (cand_d != note_q)) begin
                note_d = cand_d;
                nv_d   = 1'b1;
            end
        end
    end

    always_comb begin
        NOTE       = note_q;
        NOTE_VALID = nv_q;
        PERIOD     = period_q;
        LOCKED     = (state_q == ST_TRACK) && (match_q >= 3'(CONFIRM));
    end

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Directed and randomized tone sequences checked against an edge-level note model.
module tb_piezo_tone_decoder;

    localparam int CNT_W       = 16;
    localparam int TOL         = 2;
    localparam int CONFIRM     = 3;
    localparam int SILENCE_CYC = 2000;

    localparam int M_SIL = 0;
    localparam int M_ARM = 1;
    localparam int M_TRK = 2;

    logic             CLK     = 1'b0;
    logic             RESET   = 1'b1;
    logic             ENABLE  = 1'b1;
    logic             TONE_IN = 1'b0;
    logic [3:0]       NOTE;
    logic             NOTE_VALID;
    logic [CNT_W-1:0] PERIOD;
    logic             LOCKED;

    piezo_tone_decoder #(
        .CNT_W       (CNT_W),
        .TOL         (TOL),
        .CONFIRM     (CONFIRM),
        .SILENCE_CYC (SILENCE_CYC)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .TONE_IN    (TONE_IN),
        .NOTE       (NOTE),
        .NOTE_VALID (NOTE_VALID),
        .PERIOD     (PERIOD),
        .LOCKED     (LOCKED)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int pulses_seen = 0;

    int lim_tab [8] = '{190, 169, 151, 142, 127, 113, 100, 95};
    int m_state, m_note, m_cand, m_match, m_period, m_pulses;
    int gap_acc;

    always @(negedge CLK) begin
        if (NOTE_VALID === 1'b1) pulses_seen++;
    end

    function automatic int classify(input int c);
        if (c <= 1) return 0;
        for (int i = 0; i < 8; i++) begin
            if (((c > lim_tab[i]) ? c - lim_tab[i] : lim_tab[i] - c) <= TOL) return i + 1;
        end
        return 15;
    endfunction

    task automatic m_reset();
        m_state = M_SIL; m_note = 0; m_cand = 0; m_match = 0; m_period = 0;
    endtask

    task automatic m_silence();
        if (m_note != 0) m_pulses++;
        m_note  = 0;
        m_match = 0;
        m_state = M_SIL;
    endtask

    // One input transition, gap = clocks since the previous transition.
    task automatic m_edge(input int gap);
        int c, k;
        if (m_state != M_SIL && gap > SILENCE_CYC) m_silence();
        c = (gap - 1 > 65535) ? 65535 : gap - 1;
        k = classify(c);
        if (m_state == M_SIL) begin
            m_state = M_ARM;
        end else begin
            m_period = c;
            if (m_state == M_TRK && k == m_cand) begin
                m_match = (m_match < 7) ? m_match + 1 : 7;
            end else begin
                m_cand  = k;
                m_match = 1;
            end
            m_state = M_TRK;
            if (m_match >= CONFIRM && m_cand != m_note) begin
                m_note = m_cand;
                m_pulses++;
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
        gap_acc += n;
    endtask

    task automatic toggle();
        TONE_IN = ~TONE_IN;
        m_edge(gap_acc);
        gap_acc = 0;
    endtask

    task automatic tone(input int h, input int n);
        repeat (n) begin
            wait_cyc(h);
            toggle();
        end
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        wait_cyc(n);
        RESET = 1'b0;
        m_reset();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkpoint(input string tag);
        wait_cyc(8);
        if (m_state != M_SIL && gap_acc > SILENCE_CYC + 8) m_silence();
        check({tag, "_note"},   32'(NOTE), m_note);
        check({tag, "_period"}, 32'(PERIOD), m_period);
        check({tag, "_locked"}, 32'(LOCKED), (m_state == M_TRK && m_match >= CONFIRM) ? 1 : 0);
        check({tag, "_pulses"}, pulses_seen, m_pulses);
    endtask

    initial begin
        gap_acc  = 0;
        m_pulses = 0;
        m_reset();

        do_reset(3);
        check("rst_note", 32'(NOTE), 0);
        check("rst_valid", 32'(NOTE_VALID), 0);
        check("rst_period", 32'(PERIOD), 0);
        check("rst_locked", 32'(LOCKED), 0);
        wait_cyc(5);
        check("rst_release_pulses", pulses_seen, 0);

        tone(152, 6);
        checkpoint("mi");
        check("mi_code", 32'(NOTE), 3);
        check("mi_half_period", 32'(PERIOD), 151);

        tone(98, 6);
        checkpoint("hdo");
        tone(121, 6);
        checkpoint("unknown");

        repeat (4) begin
            tone(152, 1);
            tone(191, 1);
        end
        checkpoint("alternate");

        tone(152, 5);
        checkpoint("mi_relock");
        wait_cyc(2100);
        checkpoint("timeout");
        tone(1, 20);
        checkpoint("rest_fast");

        tone(128, 5);
        checkpoint("sol");
        wait_cyc(60);
        do_reset(1);
        check("midrst_note", 32'(NOTE), 0);
        check("midrst_valid", 32'(NOTE_VALID), 0);
        check("midrst_period", 32'(PERIOD), 0);
        check("midrst_locked", 32'(LOCKED), 0);
        wait_cyc(59);
        toggle();
        tone(128, 4);
        checkpoint("sol_reacquire");

        wait_cyc(20);
        ENABLE = 1'b0;
        m_silence();
        wait_cyc(3);
        ENABLE = 1'b1;
        checkpoint("disable");
        tone(128, 5);
        checkpoint("enable_relock");

        for (int r = 0; r < 10; r++) begin
            int idx, h, n;
            idx = int'($urandom_range(0, 7));
            h   = lim_tab[idx] + 1 + int'($urandom_range(0, 8)) - 4;
            n   = int'($urandom_range(2, 7));
            tone(h, n);
            if ($urandom_range(0, 3) == 0) wait_cyc(2100);
            checkpoint($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
